// File: rtl/alu_operand_sequencer.sv
// Operator front-end for the datapath ALU: debounced enter/clear buttons step
// through operand A, operand B and opcode entry, then capture the ALU result for display.
module alu_operand_sequencer #(
  parameter int size            = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] sw,
  input  logic            btn_enter,
  input  logic            btn_clear,
  input  logic [size-1:0] alu_res,
  input  logic [3:0]      alu_flags,
  output logic [size-1:0] A,
  output logic [size-1:0] B,
  output logic [3:0]      control,
  output logic [size-1:0] display,
  output logic [3:0]      flags_q,
  output logic            res_valid,
  output logic            op_err,
  output logic [2:0]      state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // Index 0 is enter, index 1 is clear.
  logic [1:0]    sync1_r, sync2_r, press_r, lock_r;
  logic [CW-1:0] cnt_r [2];
  logic [1:0]    fill_r;

  state_t          state_r, state_n;
  logic [size-1:0] a_r, a_n, b_r, b_n, res_r, res_n;
  logic [3:0]      ctrl_r, ctrl_n, flg_r, flg_n;
  logic            valid_r, valid_n, err_r, err_n;
  logic            enter_p, clear_p;

  function automatic logic is_legal(input logic [3:0] op);
    logic ok;
    case (op)
      4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100: ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Button synchronizers and debounce counters. A button still held when
  // reset releases stays locked until it is seen low once the synchronizer
  // pipeline has refilled.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      press_r <= 2'b00;
      lock_r  <= 2'b11;
      fill_r  <= 2'd0;
      for (int i = 0; i < 2; i++) cnt_r[i] <= '0;
    end else begin
      sync1_r <= {btn_clear, btn_enter};
      sync2_r <= sync1_r;
      if (fill_r != 2'd2) fill_r <= fill_r + 2'd1;
      for (int i = 0; i < 2; i++) begin
        if (!sync2_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] != CW'(DEBOUNCE_CYCLES)) begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
        press_r[i] <= sync2_r[i] && (cnt_r[i] == CW'(DEBOUNCE_CYCLES - 1)) && !lock_r[i];
        if (fill_r == 2'd2 && !sync2_r[i]) lock_r[i] <= 1'b0;
      end
    end
  end

  assign enter_p = press_r[0];
  assign clear_p = press_r[1];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_A;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      ctrl_r  <= 4'b0000;
      flg_r   <= 4'b0000;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      a_r     <= a_n;
      b_r     <= b_n;
      res_r   <= res_n;
      ctrl_r  <= ctrl_n;
      flg_r   <= flg_n;
      valid_r <= valid_n;
      err_r   <= err_n;
    end
  end

  // Next-state and register-update logic; clear overrides everything.
  always_comb begin
    state_n = state_r;
    a_n     = a_r;
    b_n     = b_r;
    res_n   = res_r;
    ctrl_n  = ctrl_r;
    flg_n   = flg_r;
    valid_n = valid_r;
    err_n   = 1'b0;
    case (state_r)
      S_A: begin
        if (enter_p) begin
          a_n     = sw;
          state_n = S_B;
        end else begin
          state_n = S_A;
        end
      end
      S_B: begin
        if (enter_p) begin
          b_n     = sw;
          state_n = S_OP;
        end else begin
          state_n = S_B;
        end
      end
      S_OP: begin
        if (enter_p && is_legal(sw[3:0])) begin
          ctrl_n  = sw[3:0];
          state_n = S_EXEC;
        end else if (enter_p) begin
          err_n   = 1'b1;
        end else begin
          state_n = S_OP;
        end
      end
      S_EXEC: begin
        res_n   = alu_res;
        flg_n   = alu_flags;
        valid_n = 1'b1;
        state_n = S_SHOW;
      end
      S_SHOW: begin
        if (enter_p) begin
          ctrl_n  = 4'b0000;
          valid_n = 1'b0;
          state_n = S_A;
        end else begin
          state_n = S_SHOW;
        end
      end
      default: begin
        state_n = S_A;
      end
    endcase
    if (clear_p) begin
      state_n = S_A;
      a_n     = '0;
      b_n     = '0;
      res_n   = '0;
      ctrl_n  = 4'b0000;
      flg_n   = 4'b0000;
      valid_n = 1'b0;
      err_n   = 1'b0;
    end else begin
      err_n   = err_n;
    end
  end

  assign A         = a_r;
  assign B         = b_r;
  assign control   = ctrl_r;
  assign flags_q   = flg_r;
  assign res_valid = valid_r;
  assign op_err    = err_r;
  assign state     = state_r;
  assign display   = (state_r == S_EXEC || state_r == S_SHOW) ? res_r : sw;

endmodule
